// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NIBBLE_W   - width of the shared adder slice
//   state_t    - sequencer states IDLE / RUN / DONE
//   signed_ovf - two's-complement overflow from operand and result MSBs
package add_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Overflow occurs only when both addends share a sign and the result
   // sign differs from it. For subtract, b_msb is the MSB of the
   // inverted operand, so the same rule covers both operations.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/nibble_add_4.sv
// Combinational 4-bit adder slice with carry in/out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a, b  - nibble operands
//   cin   - carry in
//   s     - nibble sum
//   cout  - carry out of bit 3
module nibble_add_4
   import add_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   // One extra bit on each term keeps the carry out of the top bit.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit slice, LSB nibble first.
// Latency: done_0 pulses WIDTH/4 cycles after the accepting edge; one op per WIDTH/4+2 cycles.
// Backpressure: start_i is only sampled in IDLE; requests while busy_0 is high are dropped.
//
// Ports:
//   clk_i, rst_n_i  - clock (rising edge), asynchronous active-low reset
//   start_i         - request; accepted on an edge while idle
//   a_i, b_i        - operands, sampled on the accepting edge
//   c_i             - carry-in for add; ignored for subtract
//   sub_i           - 1 = a_i - b_i, 0 = a_i + b_i + c_i
//   busy_0          - high while an operation is in flight (RUN or DONE)
//   done_0          - one-cycle pulse; sum_0/carry_0/overflow_0 valid
//   sum_0           - result, modulo 2^WIDTH
//   carry_0         - final carry-out; for subtract, 1 means no borrow
//   overflow_0      - signed two's-complement overflow
//
// WIDTH must be a multiple of 4 and at least 4.
module nibble_add_seq
   import add_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   input  logic             sub_i,
   output logic             busy_0,
   output logic             done_0,
   output logic [WIDTH-1:0] sum_0,
   output logic             carry_0,
   output logic             overflow_0
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   // B is stored already inverted for subtract, so the slice only ever adds.
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc_q;

   logic [WIDTH-1:0]   sum_q;
   logic               carry_out_q;
   logic               ovf_q;

   // Nibble select: shift the current nibble down to bit 0.
   logic [IDX_W+1:0]    shamt;
   logic [WIDTH-1:0]    a_shift;
   logic [WIDTH-1:0]    b_shift;
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] s_nib;
   logic                cout;
   logic [WIDTH-1:0]    acc_nxt;

   assign shamt   = {idx_q, 2'b00};
   assign a_shift = a_q >> shamt;
   assign b_shift = b_q >> shamt;
   assign a_nib   = a_shift[NIBBLE_W-1:0];
   assign b_nib   = b_shift[NIBBLE_W-1:0];

   nibble_add_4 u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .s    (s_nib),
      .cout (cout)
   );

   // Accumulator with the current nibble replaced by the slice output.
   // On the last nibble this is the complete result, which is why it
   // (not acc_q) feeds the result registers.
   always_comb begin
      acc_nxt = acc_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            acc_nxt[i*NIBBLE_W +: NIBBLE_W] = s_nib;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= sub_i ? ~b_i : b_i;
                  // Subtract is A + ~B + 1; the +1 rides in as carry-in.
                  carry_q <= sub_i ? 1'b1 : c_i;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end

            RUN: begin
               acc_q   <= acc_nxt;
               carry_q <= cout;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  state_q     <= DONE;
                  sum_q       <= acc_nxt;
                  carry_out_q <= cout;
                  ovf_q       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                            acc_nxt[WIDTH-1]);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_0     = (state_q != IDLE);
   assign done_0     = (state_q == DONE);
   assign sum_0      = sum_q;
   assign carry_0    = carry_out_q;
   assign overflow_0 = ovf_q;

endmodule
